// File: rtl/eth_tx_gmii_if.sv
// Frame-assembler to GMII transmit stage bundle: octet stream in, GMII plus frame status out.
interface eth_tx_gmii_if #(
    parameter int unsigned jumbo_dw = 14
);
    logic [7:0]          eth_octet;
    logic                eth_strobe;
    logic                tx_ready;
    logic [7:0]          gmii_txd;
    logic                gmii_tx_en;
    logic                gmii_tx_er;
    logic [jumbo_dw-1:0] frame_len;
    logic                frame_done;
    logic                err_runt;
    logic                err_long;
    logic                err_ifg;
    logic                err_preamble;
    logic [15:0]         frame_count;

    modport master (
        output eth_octet, eth_strobe,
        input  tx_ready, gmii_txd, gmii_tx_en, gmii_tx_er, frame_len, frame_done,
        input  err_runt, err_long, err_ifg, err_preamble, frame_count
    );

    modport slave (
        input  eth_octet, eth_strobe,
        output tx_ready, gmii_txd, gmii_tx_en, gmii_tx_er, frame_len, frame_done,
        output err_runt, err_long, err_ifg, err_preamble, frame_count
    );
endinterface

// File: rtl/eth_tx_gmii.sv
// GMII transmit output stage: registers octets onto GMII, enforces IFG, measures/flags frames.
// Optional preamble/SFD check enabled by defining ETH_TX_PREAMBLE_CHECK_EN.
module eth_tx_gmii #(
    parameter int unsigned jumbo_dw  = 14,
    parameter int unsigned ifg       = 12,
    parameter int unsigned min_frame = 72,
    parameter int unsigned max_frame = 9030
) (
    input logic          clk,
    input logic          rst_n,
    eth_tx_gmii_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFrame, StGap, StDrop} state_e;

    localparam logic [jumbo_dw-1:0] LenSat = '1;
    localparam logic [jumbo_dw-1:0] MaxLen = jumbo_dw'(max_frame);
    localparam logic [jumbo_dw-1:0] MinLen = jumbo_dw'(min_frame);
    localparam logic [jumbo_dw-1:0] LenOne = jumbo_dw'(1);
    localparam logic [7:0]          IfgLen = 8'(ifg);

    state_e              state_q, state_d;
    logic [jumbo_dw-1:0] len_q, len_d, frame_len_q, frame_len_d;
    logic [7:0]          gap_q, gap_d, txd_q, txd_d;
    logic [15:0]         count_q, count_d;
    logic                tx_en_q, tx_en_d, tx_er_q, tx_er_d, ready_q, ready_d;
    logic                done_q, done_d, runt_q, runt_d, long_q, long_d;
    logic                ifg_err_q, ifg_err_d;
    logic                strobe;
    logic [7:0]          octet;

    assign strobe = bus.eth_strobe;
    assign octet  = bus.eth_octet;

`ifdef ETH_TX_PREAMBLE_CHECK_EN
    logic pre_bad_q, pre_bad_d, pre_err_q, pre_err_d;

    always_comb begin
        pre_bad_d = pre_bad_q;
        pre_err_d = 1'b0;
        unique case (state_q)
            StIdle:  if (strobe) pre_bad_d = (octet != 8'h55);
            StFrame: begin
                // len_q octets already seen, so the current octet is number len_q+1
                if (strobe && len_q < jumbo_dw'(7)) begin
                    pre_bad_d = pre_bad_q | (octet != 8'h55);
                end else if (strobe && len_q == jumbo_dw'(7)) begin
                    pre_bad_d = pre_bad_q | (octet != 8'hd5);
                end else if (!strobe) begin
                    pre_err_d = pre_bad_q | (len_q < jumbo_dw'(8));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_bad_q <= 1'b0;
            pre_err_q <= 1'b0;
        end else begin
            pre_bad_q <= pre_bad_d;
            pre_err_q <= pre_err_d;
        end
    end

    assign bus.err_preamble = pre_err_q;
`else
    assign bus.err_preamble = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        gap_d       = gap_q;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        done_d      = 1'b0;
        runt_d      = 1'b0;
        long_d      = 1'b0;
        ifg_err_d   = 1'b0;
        frame_len_d = frame_len_q;
        count_d     = count_q;
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    state_d = StFrame;
                    len_d   = LenOne;
                    txd_d   = octet;
                    tx_en_d = 1'b1;
                end
            end
            StFrame: begin
                if (strobe) begin
                    len_d = (len_q == LenSat) ? len_q : len_q + LenOne;
                    if (len_q < MaxLen) begin
                        txd_d   = octet;
                        tx_en_d = 1'b1;
                    end else if (len_q == MaxLen) begin
                        // Truncate: one errored cycle closes the GMII frame
                        tx_en_d = 1'b1;
                        tx_er_d = 1'b1;
                    end
                end else begin
                    state_d     = StGap;
                    gap_d       = 8'd1;
                    done_d      = 1'b1;
                    frame_len_d = len_q;
                    runt_d      = (len_q < MinLen);
                    long_d      = (len_q > MaxLen);
                    count_d     = count_q + 16'd1;
                end
            end
            StGap: begin
                if (strobe) begin
                    state_d   = StDrop;
                    ifg_err_d = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                    if (gap_q + 8'd1 == IfgLen) state_d = StIdle;
                end
            end
            StDrop: begin
                if (!strobe) begin
                    state_d = StGap;
                    gap_d   = 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            gap_q       <= '0;
            txd_q       <= '0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            runt_q      <= 1'b0;
            long_q      <= 1'b0;
            ifg_err_q   <= 1'b0;
            frame_len_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            runt_q      <= runt_d;
            long_q      <= long_d;
            ifg_err_q   <= ifg_err_d;
            frame_len_q <= frame_len_d;
            count_q     <= count_d;
        end
    end

    assign bus.tx_ready    = ready_q;
    assign bus.gmii_txd    = txd_q;
    assign bus.gmii_tx_en  = tx_en_q;
    assign bus.gmii_tx_er  = tx_er_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.frame_done  = done_q;
    assign bus.err_runt    = runt_q;
    assign bus.err_long    = long_q;
    assign bus.err_ifg     = ifg_err_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_eth_tx_gmii.sv
// Directed bench for eth_tx_gmii (ifg=12, min_frame=72, max_frame=100).
module tb_eth_tx_gmii;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    // Per-play observations
    int en_cnt, er_cnt, er_idx, txd_bad, done_cnt, done_en, ifg_cnt, runt_cnt, busy_rdy;
    int len_cap, runt_cap, long_cap, pre_cap, ready_end;

    eth_tx_gmii_if #(.jumbo_dw(14)) bus ();

    eth_tx_gmii #(
        .jumbo_dw (14),
        .ifg      (12),
        .min_frame(72),
        .max_frame(100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] oct(input int i, input bit bad_sfd);
        if (i < 7) return 8'h55;
        if (i == 7) return bad_sfd ? 8'h55 : 8'hd5;
        return 8'(i * 7 + 3);
    endfunction

    // Called at a negedge; drives n strobe-high octets then tail strobe-low cycles.
    task automatic play(input int n, input bit bad_sfd, input int tail);
        logic [7:0] o;
        en_cnt = 0; er_cnt = 0; er_idx = -1; txd_bad = 0; done_cnt = 0; done_en = 0;
        ifg_cnt = 0; runt_cnt = 0; busy_rdy = 0;
        len_cap = -1; runt_cap = -1; long_cap = -1; pre_cap = -1;
        for (int i = 0; i < n + tail; i++) begin
            o = (i < n) ? oct(i, bad_sfd) : 8'h00;
            bus.eth_strobe = (i < n);
            bus.eth_octet  = o;
            @(negedge clk);
            if (bus.gmii_tx_en) en_cnt++;
            if (bus.gmii_tx_er) begin er_cnt++; er_idx = i; end
            if (bus.gmii_tx_en && !bus.gmii_tx_er && (i >= n || bus.gmii_txd !== o)) txd_bad++;
            if (!bus.gmii_tx_en && bus.gmii_txd !== 8'h00) txd_bad++;
            if (bus.err_ifg) ifg_cnt++;
            if (bus.err_runt) runt_cnt++;
            if (i < n && bus.tx_ready) busy_rdy++;
            if (bus.frame_done) begin
                done_cnt++;
                if (bus.gmii_tx_en) done_en++;
                len_cap  = int'(bus.frame_len);
                runt_cap = int'(bus.err_runt);
                long_cap = int'(bus.err_long);
                pre_cap  = int'(bus.err_preamble);
            end
        end
        ready_end = int'(bus.tx_ready);
    endtask

    task automatic test_reset();
        bus.eth_strobe = 1'b0;
        bus.eth_octet  = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.tx_ready); end
        total++; if ({bus.gmii_tx_en, bus.gmii_tx_er, bus.gmii_txd} !== 10'd0) begin
            bad++; $display("FAIL rst_gmii got=%b/%b/%h want=0/0/00", bus.gmii_tx_en, bus.gmii_tx_er, bus.gmii_txd); end
        total++; if ({bus.frame_done, bus.err_runt, bus.err_long, bus.err_ifg, bus.err_preamble} !== 5'd0) begin
            bad++; $display("FAIL rst_flags got=%b want=00000", {bus.frame_done, bus.err_runt, bus.err_long, bus.err_ifg, bus.err_preamble}); end
        total++; if (bus.frame_count !== 16'd0 || bus.frame_len !== 14'd0) begin
            bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", bus.frame_count, bus.frame_len); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_early got=%b want=0", bus.tx_ready); end
        @(negedge clk);
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b want=1", bus.tx_ready); end
    endtask

    task automatic test_clean_frame();
        play(72, 1'b0, 13);
        total++; if (en_cnt !== 72 || txd_bad !== 0) begin bad++; $display("FAIL clean_gmii got en=%0d txd_bad=%0d want en=72 txd_bad=0", en_cnt, txd_bad); end
        total++; if (done_cnt !== 1 || done_en !== 0) begin bad++; $display("FAIL clean_done got=%0d overlap=%0d want=1/0", done_cnt, done_en); end
        total++; if (len_cap !== 72) begin bad++; $display("FAIL clean_len got=%0d want=72", len_cap); end
        total++; if (runt_cap !== 0 || long_cap !== 0 || pre_cap !== 0 || er_cnt !== 0 || ifg_cnt !== 0) begin
            bad++; $display("FAIL clean_errs got runt=%0d long=%0d pre=%0d er=%0d ifg=%0d want all 0", runt_cap, long_cap, pre_cap, er_cnt, ifg_cnt); end
        total++; if (bus.frame_count !== 16'd1) begin bad++; $display("FAIL clean_count got=%0d want=1", bus.frame_count); end
        total++; if (busy_rdy !== 0 || ready_end !== 1) begin bad++; $display("FAIL clean_ready got busy=%0d end=%0d want 0/1", busy_rdy, ready_end); end
    endtask

    task automatic test_runt();
        play(40, 1'b0, 13);
        total++; if (en_cnt !== 40 || txd_bad !== 0) begin bad++; $display("FAIL runt_gmii got en=%0d txd_bad=%0d want 40/0", en_cnt, txd_bad); end
        total++; if (done_cnt !== 1 || runt_cap !== 1 || runt_cnt !== 1) begin
            bad++; $display("FAIL runt_flag got done=%0d runt=%0d pulses=%0d want 1/1/1", done_cnt, runt_cap, runt_cnt); end
        total++; if (len_cap !== 40 || long_cap !== 0) begin bad++; $display("FAIL runt_len got=%0d long=%0d want 40/0", len_cap, long_cap); end
        total++; if (bus.frame_count !== 16'd2) begin bad++; $display("FAIL runt_count got=%0d want=2", bus.frame_count); end
    endtask

    task automatic test_ifg();
        play(72, 1'b0, 5);
        total++; if (ready_end !== 0 || bus.frame_count !== 16'd3) begin
            bad++; $display("FAIL ifg_pre got ready=%0d count=%0d want 0/3", ready_end, bus.frame_count); end
        play(30, 1'b0, 12);
        total++; if (ifg_cnt !== 1) begin bad++; $display("FAIL ifg_pulse got=%0d want=1", ifg_cnt); end
        total++; if (en_cnt !== 0 || done_cnt !== 0) begin bad++; $display("FAIL ifg_drop got en=%0d done=%0d want 0/0", en_cnt, done_cnt); end
        total++; if (bus.frame_count !== 16'd3) begin bad++; $display("FAIL ifg_count got=%0d want=3", bus.frame_count); end
        total++; if (ready_end !== 1) begin bad++; $display("FAIL ifg_ready got=%0d want=1", ready_end); end
        play(72, 1'b0, 13);
        total++; if (en_cnt !== 72 || done_cnt !== 1 || len_cap !== 72 || ifg_cnt !== 0) begin
            bad++; $display("FAIL ifg_next got en=%0d done=%0d len=%0d ifg=%0d want 72/1/72/0", en_cnt, done_cnt, len_cap, ifg_cnt); end
        total++; if (bus.frame_count !== 16'd4) begin bad++; $display("FAIL ifg_next_count got=%0d want=4", bus.frame_count); end
    endtask

    task automatic test_long();
        play(120, 1'b0, 13);
        total++; if (en_cnt !== 101 || txd_bad !== 0) begin bad++; $display("FAIL long_en got=%0d txd_bad=%0d want 101/0", en_cnt, txd_bad); end
        total++; if (er_cnt !== 1 || er_idx !== 100) begin bad++; $display("FAIL long_er got cnt=%0d at=%0d want 1 at 100", er_cnt, er_idx); end
        total++; if (long_cap !== 1 || runt_cap !== 0 || len_cap !== 120) begin
            bad++; $display("FAIL long_flags got long=%0d runt=%0d len=%0d want 1/0/120", long_cap, runt_cap, len_cap); end
        total++; if (bus.frame_count !== 16'd5) begin bad++; $display("FAIL long_count got=%0d want=5", bus.frame_count); end
    endtask

    task automatic test_preamble();
        int want;
`ifdef ETH_TX_PREAMBLE_CHECK_EN
        want = 1;
`else
        want = 0;
`endif
        play(72, 1'b1, 13);
        total++; if (done_cnt !== 1 || pre_cap !== want) begin bad++; $display("FAIL preamble got done=%0d pre=%0d want 1/%0d", done_cnt, pre_cap, want); end
        total++; if (en_cnt !== 72 || txd_bad !== 0) begin bad++; $display("FAIL preamble_fwd got en=%0d txd_bad=%0d want 72/0", en_cnt, txd_bad); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 30; i++) begin
            bus.eth_strobe = 1'b1;
            bus.eth_octet  = oct(i, 1'b0);
            @(negedge clk);
        end
        total++; if (bus.gmii_tx_en !== 1'b1) begin bad++; $display("FAIL mid_en_before got=%b want=1", bus.gmii_tx_en); end
        bus.eth_octet = oct(30, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.gmii_tx_en !== 1'b0 || bus.gmii_txd !== 8'h00 || bus.tx_ready !== 1'b0) begin
            bad++; $display("FAIL mid_async got en=%b txd=%h rdy=%b want 0/00/0", bus.gmii_tx_en, bus.gmii_txd, bus.tx_ready); end
        bus.eth_strobe = 1'b0;
        bus.eth_octet  = 8'h00;
        @(negedge clk);
        total++; if (bus.frame_done !== 1'b0 || bus.frame_count !== 16'd0) begin
            bad++; $display("FAIL mid_nodone got done=%b count=%0d want 0/0", bus.frame_done, bus.frame_count); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", bus.tx_ready); end
        play(72, 1'b0, 13);
        total++; if (done_cnt !== 1 || len_cap !== 72 || en_cnt !== 72 || bus.frame_count !== 16'd1) begin
            bad++; $display("FAIL mid_next got done=%0d len=%0d en=%0d count=%0d want 1/72/72/1", done_cnt, len_cap, en_cnt, bus.frame_count); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_runt();
        test_ifg();
        test_long();
        test_preamble();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
